// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add on operand magnitudes; divide is restoring shift-subtract.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]   operand, acc, mq, a_orig;
    logic [WIDTH-1:0]   a_mag, b_mag, step_acc, step_mq, res_hi, res_lo;
    logic [WIDTH:0]     sum, shifted;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [CW-1:0]      count;
    logic               is_div, neg_q, neg_r, div_zero;
    logic               signed_op, a_neg, b_neg;
    logic               idle_req, issue_md, issue_mthi, issue_mtlo;

    // flush in IDLE discards any simultaneous request, including MTHI/MTLO
    assign idle_req   = (state == IDLE) && start && !flush;
    assign issue_md   = idle_req && !op[2];
    assign issue_mthi = idle_req && (op == OP_MTHI);
    assign issue_mtlo = idle_req && (op == OP_MTLO);

    assign signed_op = !op[0];
    assign a_neg     = signed_op && a[WIDTH-1];
    assign b_neg     = signed_op && b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (issue_md) state_next = RUN;
            RUN:  if (flush || count == '0) state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_comb begin
        sum      = '0;
        shifted  = '0;
        diff     = '0;
        step_acc = acc;
        step_mq  = mq;
        if (is_div) begin
            // partial remainder stays below the divisor, so a non-negative diff fits in WIDTH bits
            shifted = {acc, mq[WIDTH-1]};
            diff    = {1'b0, shifted} - {2'b00, operand};
            if (diff[WIDTH+1:WIDTH] == 2'b00) begin
                step_acc = diff[WIDTH-1:0];
                step_mq  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = shifted[WIDTH-1:0];
                step_mq  = {mq[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum      = {1'b0, acc} + {1'b0, operand & {WIDTH{mq[0]}}};
            step_acc = sum[WIDTH:1];
            step_mq  = {sum[0], mq[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_fix = neg_q ? -{step_acc, step_mq} : {step_acc, step_mq};
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            res_lo = neg_q ? -step_mq : step_mq;
            res_hi = neg_r ? -step_acc : step_acc;
            if (div_zero) begin
                res_lo = '1;
                res_hi = a_orig;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            acc      <= '0;
            mq       <= '0;
            operand  <= '0;
            a_orig   <= '0;
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (issue_md) begin
                acc      <= '0;
                mq       <= a_mag;
                operand  <= b_mag;
                a_orig   <= a;
                count    <= CW'(WIDTH - 1);
                is_div   <= op[1];
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= op[1] && (b == '0);
            end else if (state == RUN && !flush) begin
                acc   <= step_acc;
                mq    <= step_mq;
                count <= count - CW'(1);
                if (count == '0) begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
            end
            if (issue_mthi) hi <= a;
            if (issue_mtlo) lo <= a;
        end
    end

endmodule
